// File: rtl/fpu_pkg.sv
// fpu_pkg: opcodes, float field ranges, constants and FSM states
// shared by the 16-bit multi-cycle FP responder and its helpers.
package fpu_pkg;

   localparam logic [2:0] FOP_ADDF = 3'd0;
   localparam logic [2:0] FOP_SUBF = 3'd1;
   localparam logic [2:0] FOP_MULF = 3'd2;
   localparam logic [2:0] FOP_RECF = 3'd3;
   localparam logic [2:0] FOP_ITOF = 3'd4;
   localparam logic [2:0] FOP_FTOI = 3'd5;

   localparam int SIGN_BIT = 15;
   localparam int EXP_HI   = 14;
   localparam int EXP_LO   = 7;
   localparam int MANT_HI  = 6;
   localparam int MANT_LO  = 0;

   localparam int          BIAS = 127;
   localparam logic [14:0] FMAX = 15'h7F7F;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ALIGN,
      S_CALC,
      S_NORM,
      S_RECIP,
      S_DONE
   } fpu_state_e;

   // Pack a normalised result, saturating or flushing out-of-range exponents.
   function automatic logic [15:0] fp_pack(
      input logic              s,
      input logic signed [9:0] e,
      input logic [6:0]        m
   );
      if (e > 10'sd254)
         return {s, FMAX};
      else if (e < 10'sd1)
         return 16'h0000;
      else
         return {s, e[7:0], m};
   endfunction

endpackage

// File: rtl/fpu_recip.sv
// fpu_recip: reciprocal mantissa floor(32768/(128+m))-128 behind start/done.
// FPU_RECIP_TABLE_EN selects a 1-cycle ROM; otherwise an 8-cycle divider.
module fpu_recip
   import fpu_pkg::*;
#(
   parameter string RECIP_FILE = "reciprocal_look.mem"
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_start,
   input  logic [6:0] i_mant,
   output logic       o_done,
   output logic [6:0] o_mant
);

`ifdef FPU_RECIP_TABLE_EN
   logic [7:0] r_rom [0:127];
   logic       r_done;
   logic [6:0] r_mant;

   initial begin
      for (int i = 0; i < 128; i++)
         r_rom[i] = 8'((32768 / (128 + i)) - 128);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_done <= 1'b0;
         r_mant <= 7'h00;
      end else begin
         r_done <= i_start;
         if (i_start)
            r_mant <= r_rom[i_mant][MANT_HI:MANT_LO];
      end
   end

   assign o_done = r_done;
   assign o_mant = r_mant;
`else
   logic       r_busy;
   logic       r_done;
   logic [2:0] r_cnt;
   logic [7:0] r_rem;
   logic [7:0] r_d;
   logic [6:0] r_q;
   logic [8:0] w_t;
   logic       w_ge;

   // Remainder stays below the divisor, so one doubled step fits 9 bits.
   assign w_t  = {r_rem, 1'b0};
   assign w_ge = w_t >= {1'b0, r_d};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_cnt  <= 3'd0;
         r_rem  <= 8'h00;
         r_d    <= 8'h00;
         r_q    <= 7'h00;
      end else begin
         r_done <= 1'b0;
         if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= 3'd0;
            r_rem  <= 8'h80;
            r_d    <= {1'b1, i_mant};
            r_q    <= 7'h00;
         end else if (r_busy) begin
            r_rem <= w_ge ? 8'(w_t - {1'b0, r_d})
                          : w_t[7:0];
            r_q   <= {r_q[5:0], w_ge};
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end
         end
      end
   end

   assign o_done = r_done;
   assign o_mant = r_q;
`endif

endmodule

// File: rtl/fpu_responder.sv
// fpu_responder: multi-cycle 16-bit FP unit (add/sub/mul/recip/itof/ftoi).
// Build option FPU_RECIP_TABLE_EN picks the ROM reciprocal in fpu_recip.
module fpu_responder
   import fpu_pkg::*;
#(
   parameter int    ALIGN_MAX  = 8,
   parameter string RECIP_FILE = "reciprocal_look.mem"
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [15:0] req_a,
   input  logic [15:0] req_b,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [15:0] resp_data,
   output logic        resp_err
);

   localparam logic [7:0]        LP_AMAX = 8'(ALIGN_MAX);
   localparam logic signed [9:0] LP_BIAS = 10'(BIAS);

   fpu_state_e r_state, w_state_nxt;

   logic [2:0]        r_op;
   logic              r_sa, r_sb, r_s;
   logic [7:0]        r_ea, r_eb, r_ma, r_mb;
   logic signed [9:0] r_e;
   logic [15:0]       r_m;
   logic [15:0]       r_data;
   logic              r_err;

   logic [7:0]        w_ea_in, w_eb_in;
   logic              w_ill, w_a_zero;
   logic              w_rstart, w_rdone;
   logic [6:0]        w_rmant;
   logic              w_a_big, w_align_last;
   logic [7:0]        w_diff;
   logic [8:0]        w_sum;
   logic              w_ssign;
   logic [15:0]       w_prod;
   logic signed [9:0] w_mexp;
   logic              w_mzero;
   logic [3:0]        w_fsh;
   logic [14:0]       w_fmag;
   logic [15:0]       w_ftoi;
   logic signed [9:0] w_rexp;

   assign w_ea_in  = req_a[EXP_HI:EXP_LO];
   assign w_eb_in  = req_b[EXP_HI:EXP_LO];
   assign w_ill    = req_op > FOP_FTOI;
   assign w_a_zero = w_ea_in == 8'h00;
   assign w_rstart = (r_state == S_IDLE) && req_valid
                   && (req_op == FOP_RECF) && !w_a_zero;

   fpu_recip #(
      .RECIP_FILE (RECIP_FILE)
   ) u_recip (
      .clk     (clk),
      .reset   (reset),
      .i_start (w_rstart),
      .i_mant  (req_a[MANT_HI:MANT_LO]),
      .o_done  (w_rdone),
      .o_mant  (w_rmant)
   );

   assign w_a_big      = r_ea > r_eb;
   assign w_diff       = w_a_big ? r_ea - r_eb : r_eb - r_ea;
   assign w_align_last = (w_diff <= 8'd1) || (w_diff > LP_AMAX);

   always_comb begin
      w_sum   = 9'h000;
      w_ssign = 1'b0;
      if (r_sa == r_sb) begin
         w_sum   = {1'b0, r_ma} + {1'b0, r_mb};
         w_ssign = r_sa;
      end else if (r_ma >= r_mb) begin
         w_sum   = {1'b0, r_ma - r_mb};
         w_ssign = r_sa;
      end else begin
         w_sum   = {1'b0, r_mb - r_ma};
         w_ssign = r_sb;
      end
   end

   assign w_prod  = 16'(r_ma) * 16'(r_mb);
   assign w_mzero = (r_ea == 8'h00) || (r_eb == 8'h00);
   assign w_mexp  = $signed({2'b00, r_ea})
                  + $signed({2'b00, r_eb}) - LP_BIAS
                  + (w_prod[15] ? 10'sd1 : 10'sd0);

   // Significand scaled by 2^7 so exponents BIAS..BIAS+14 are right shifts.
   assign w_fsh  = 4'(8'(BIAS + 14) - r_ea);
   assign w_fmag = {r_ma, 7'b0} >> w_fsh;

   always_comb begin
      w_ftoi = 16'h0000;
      if (r_ea >= 8'(BIAS + 15))
         w_ftoi = r_sa ? 16'h8000 : 16'h7FFF;
      else if (r_ea >= 8'(BIAS))
         w_ftoi = r_sa ? 16'h0 - {1'b0, w_fmag}
                       : {1'b0, w_fmag};
   end

   assign w_rexp = (r_ma[6:0] == 7'h00 ? 10'sd254 : 10'sd253)
                 - $signed({2'b00, r_ea});

   always_ff @(posedge clk) begin
      if (reset)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      req_ready   = 1'b0;
      resp_valid  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (w_ill)
                  w_state_nxt = S_DONE;
               else if (req_op == FOP_ADDF || req_op == FOP_SUBF)
                  w_state_nxt = S_ALIGN;
               else if (req_op == FOP_MULF || req_op == FOP_FTOI)
                  w_state_nxt = S_CALC;
               else if (req_op == FOP_ITOF)
                  w_state_nxt = S_NORM;
               else
                  w_state_nxt = w_a_zero ? S_DONE : S_RECIP;
            end
         end
         S_ALIGN:
            if (w_align_last) w_state_nxt = S_CALC;
         S_CALC: begin
            if (r_op == FOP_FTOI)
               w_state_nxt = S_DONE;
            else if (r_op == FOP_MULF)
               w_state_nxt = w_mzero ? S_DONE : S_NORM;
            else
               w_state_nxt = (w_sum == 9'h0) ? S_DONE : S_NORM;
         end
         S_NORM:
            if (r_m[15] || r_m == 16'h0) w_state_nxt = S_DONE;
         S_RECIP:
            if (w_rdone) w_state_nxt = S_DONE;
         S_DONE: begin
            resp_valid = 1'b1;
            if (resp_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_op   <= 3'd0;
         r_sa   <= 1'b0;
         r_sb   <= 1'b0;
         r_s    <= 1'b0;
         r_ea   <= 8'h00;
         r_eb   <= 8'h00;
         r_ma   <= 8'h00;
         r_mb   <= 8'h00;
         r_e    <= 10'sd0;
         r_m    <= 16'h0000;
         r_data <= 16'h0000;
         r_err  <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: if (req_valid) begin
               r_op   <= req_op;
               r_sa   <= req_a[SIGN_BIT];
               r_sb   <= req_b[SIGN_BIT] ^ (req_op == FOP_SUBF);
               r_s    <= req_a[SIGN_BIT];
               r_ea   <= w_ea_in;
               r_eb   <= w_eb_in;
               r_ma   <= {w_ea_in != 8'h00, req_a[MANT_HI:MANT_LO]};
               r_mb   <= {w_eb_in != 8'h00, req_b[MANT_HI:MANT_LO]};
               r_e    <= LP_BIAS + 10'sd15;
               r_m    <= req_a[SIGN_BIT] ? 16'h0 - req_a : req_a;
               r_err  <= w_ill || (req_op == FOP_RECF && w_a_zero);
               r_data <= w_ill ? 16'h0000 : {req_a[SIGN_BIT], FMAX};
            end
            S_ALIGN: if (r_ea != r_eb) begin
               if (w_diff > LP_AMAX) begin
                  if (w_a_big) begin
                     r_mb <= 8'h00;
                     r_eb <= r_ea;
                  end else begin
                     r_ma <= 8'h00;
                     r_ea <= r_eb;
                  end
               end else if (w_a_big) begin
                  r_mb <= r_mb >> 1;
                  r_eb <= r_eb + 8'd1;
               end else begin
                  r_ma <= r_ma >> 1;
                  r_ea <= r_ea + 8'd1;
               end
            end
            S_CALC: begin
               if (r_op == FOP_FTOI) begin
                  r_data <= w_ftoi;
               end else if (r_op == FOP_MULF) begin
                  r_data <= 16'h0000;
                  r_s    <= r_sa ^ r_sb;
                  r_e    <= w_mexp;
                  r_m    <= {w_prod[15] ? w_prod[15:8]
                                        : w_prod[14:7], 8'h00};
               end else begin
                  r_data <= 16'h0000;
                  r_s    <= w_ssign;
                  r_e    <= $signed({2'b00, r_ea})
                          + (w_sum[8] ? 10'sd1 : 10'sd0);
                  r_m    <= {w_sum[8] ? w_sum[8:1]
                                      : w_sum[7:0], 8'h00};
               end
            end
            S_NORM: begin
               if (r_m == 16'h0000) begin
                  r_data <= 16'h0000;
               end else if (r_m[15]) begin
                  r_data <= fp_pack(r_s, r_e, r_m[14:8]);
               end else begin
                  r_m <= r_m << 1;
                  r_e <= r_e - 10'sd1;
               end
            end
            S_RECIP: if (w_rdone) begin
               r_data <= fp_pack(r_sa, w_rexp,
                  (r_ma[6:0] == 7'h00) ? 7'h00 : w_rmant);
            end
            default: ;
         endcase
      end
   end

   assign resp_data = r_data;
   assign resp_err  = r_err;

endmodule

// File: tb/tb_fpu_responder.sv
// tb_fpu_responder: directed vector table, handshake/reset sequences and
// randomized ops against an arithmetic reference model.
module tb_fpu_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_op = 3'd0;
   logic [15:0] req_a = 16'h0;
   logic [15:0] req_b = 16'h0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [15:0] resp_data;
   logic        resp_err;

   always #5 clk = ~clk;

   fpu_responder dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_err   (resp_err)
   );

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      logic [2:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] d;
      logic        e;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] norm_pack(input bit s,
                                             input longint mag,
                                             input int e);
      if (mag == 0) return 16'h0000;
      while (mag >= 256) begin mag = mag >> 1; e++; end
      while (mag < 128) begin mag = mag << 1; e--; end
      if (e > 254) return {s, 15'h7F7F};
      if (e < 1) return 16'h0000;
      return {s, 8'(e), 7'(mag)};
   endfunction

   // Value of a float is sig * 2^(exp-134) with sig = 1.mant scaled by 128.
   function automatic void model(input logic [2:0] op,
                                 input logic [15:0] a,
                                 input logic [15:0] b,
                                 output logic [15:0] d,
                                 output logic e);
      int  ea, eb, ga, gb, xa, xb, ex, s, q, ma;
      bit  sa, sb;
      real v;
      ea = int'(a[14:7]);
      eb = int'(b[14:7]);
      ga = (ea == 0) ? 0 : 128 + int'(a[6:0]);
      gb = (eb == 0) ? 0 : 128 + int'(b[6:0]);
      sa = a[15];
      sb = b[15] ^ (op == 3'd1);
      d = 16'h0;
      e = 1'b0;
      case (op)
         3'd0, 3'd1: begin
            if (ea >= eb) begin
               ex = ea; xa = ga;
               xb = (ea - eb > 8) ? 0 : gb >> (ea - eb);
            end else begin
               ex = eb; xb = gb;
               xa = (eb - ea > 8) ? 0 : ga >> (eb - ea);
            end
            s = (sa ? -xa : xa) + (sb ? -xb : xb);
            d = norm_pack(s < 0, (s < 0) ? -s : s, ex);
         end
         3'd2: begin
            if (ea != 0 && eb != 0)
               d = norm_pack(sa ^ sb, longint'(ga * gb), ea + eb - 134);
         end
         3'd3: begin
            ma = int'(a[6:0]);
            if (ea == 0) begin
               e = 1'b1;
               d = {sa, 15'h7F7F};
            end else begin
               ex = (ma == 0) ? 254 - ea : 253 - ea;
               q  = (ma == 0) ? 0 : 32768 / (128 + ma) - 128;
               d  = (ex < 1) ? 16'h0 : {sa, 8'(ex), 7'(q)};
            end
         end
         3'd4: begin
            s = int'($signed(a));
            d = norm_pack(s < 0, (s < 0) ? -s : s, 134);
         end
         3'd5: begin
            v = real'(ga) * (2.0 ** (ea - 134));
            if (v >= 32768.0) d = sa ? 16'h8000 : 16'h7FFF;
            else begin
               s = $rtoi(v);
               d = sa ? 16'(-s) : 16'(s);
            end
         end
         default: begin
            e = 1'b1;
            d = 16'h0;
         end
      endcase
   endfunction

   task automatic do_op(input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, output logic [15:0] d,
                        output logic e, output int lat);
      int w = 0;
      while (!req_ready && w < 40) begin
         @(negedge clk);
         w++;
      end
      req_valid = 1'b1;
      req_op = op;
      req_a = a;
      req_b = b;
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      d = resp_data;
      e = resp_err;
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] d, md, a, b;
      logic        e, me;
      logic [2:0]  op;
      int          lat, cnt;

      vecs.push_back('{3'd4, 16'h0003, 16'h0000, 16'h4040, 1'b0});
      vecs.push_back('{3'd4, 16'hFFFE, 16'h0000, 16'hC000, 1'b0});
      vecs.push_back('{3'd4, 16'h0000, 16'h0000, 16'h0000, 1'b0});
      vecs.push_back('{3'd0, 16'h3F80, 16'h4000, 16'h4040, 1'b0});
      vecs.push_back('{3'd1, 16'h4040, 16'h4040, 16'h0000, 1'b0});
      vecs.push_back('{3'd0, 16'h4780, 16'h3F80, 16'h4780, 1'b0});
      vecs.push_back('{3'd2, 16'h3FC0, 16'h4000, 16'h4040, 1'b0});
      vecs.push_back('{3'd2, 16'h7F00, 16'h7F00, 16'h7F7F, 1'b0});
      vecs.push_back('{3'd3, 16'h4000, 16'h0000, 16'h3F00, 1'b0});
      vecs.push_back('{3'd3, 16'h4040, 16'h0000, 16'h3EAA, 1'b0});
      vecs.push_back('{3'd5, 16'h4040, 16'h0000, 16'h0003, 1'b0});
      vecs.push_back('{3'd5, 16'hC000, 16'h0000, 16'hFFFE, 1'b0});
      vecs.push_back('{3'd5, 16'h4780, 16'h0000, 16'h7FFF, 1'b0});
      vecs.push_back('{3'd5, 16'h3F00, 16'h0000, 16'h0000, 1'b0});
      vecs.push_back('{3'd6, 16'h1234, 16'h5678, 16'h0000, 1'b1});
      vecs.push_back('{3'd7, 16'h4040, 16'h4040, 16'h0000, 1'b1});
      vecs.push_back('{3'd3, 16'h0000, 16'h0000, 16'h7F7F, 1'b1});
      vecs.push_back('{3'd0, 16'h3F80, 16'hBF00, 16'h3F00, 1'b0});

      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("rst req_ready", req_ready, 1);
      chk("rst resp_valid", resp_valid, 0);
      chk("rst resp_data", resp_data, 16'h0);
      chk("rst resp_err", resp_err, 0);

      foreach (vecs[i]) begin
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, d, e, lat);
         chk($sformatf("vec%0d data", i), d, vecs[i].d);
         chk($sformatf("vec%0d err", i), e, vecs[i].e);
         chk($sformatf("vec%0d latency", i), lat <= 22, 1);
      end

      // Result must hold while the initiator stalls; new requests ignored.
      req_valid = 1'b1;
      req_op = 3'd0;
      req_a = 16'h3F80;
      req_b = 16'h4000;
      @(negedge clk);
      req_op = 3'd4;
      req_a = 16'h0005;
      cnt = 0;
      while (!resp_valid && cnt < 40) begin
         @(negedge clk);
         cnt++;
      end
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("stall%0d valid", k), resp_valid, 1);
         chk($sformatf("stall%0d data", k), resp_data, 16'h4040);
         chk($sformatf("stall%0d req_ready", k), req_ready, 0);
         @(negedge clk);
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk("release req_ready", req_ready, 1);
      chk("release resp_valid", resp_valid, 0);

      // Abort an addf while it is still aligning exponents.
      req_valid = 1'b1;
      req_op = 3'd0;
      req_a = 16'h4280;
      req_b = 16'h3F80;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("abort req_ready", req_ready, 1);
      chk("abort resp_valid", resp_valid, 0);
      reset = 1'b0;
      cnt = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (resp_valid) cnt++;
      end
      chk("abort no stale resp", cnt, 0);

      do_op(3'd4, 16'h0003, 16'h0, d, e, lat);
      chk("post-abort itof", d, 16'h4040);

      for (int n = 0; n < 300; n++) begin
         op = 3'($urandom_range(0, 7));
         a = 16'($urandom);
         b = 16'($urandom);
         if ($urandom_range(0, 1) == 1)
            b[14:7] = a[14:7] + 8'($urandom_range(0, 10)) - 8'd5;
         if ($urandom_range(0, 3) == 0)
            a[14:7] = 8'(127 + $urandom_range(0, 16));
         model(op, a, b, md, me);
         do_op(op, a, b, d, e, lat);
         chk($sformatf("rnd%0d op%0d a=%h b=%h data", n, op, a, b),
             d, md);
         chk($sformatf("rnd%0d err", n), e, me);
         chk($sformatf("rnd%0d latency", n), lat <= 22, 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
